bcd_7seg_scan: RTL and testbench

BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

---
 rtl/bcd_disp_pkg.sv | 40 ++++
 rtl/bcd_to_7seg.sv | 36 +++
 rtl/bcd_7seg_scan.sv | 155 +++++++++++++++
 tb/tb_bcd_7seg_scan.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared constants and types for the 3-digit BCD 7-segment
//               scanner: segment codes ({g,f,e,d,c,b,a}, active-high),
//               digit count and digit-index encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 3;

    // Segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit slot currently being driven; value doubles as nibble position
    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_e;

    // A nibble above 9 is not a legal BCD digit
    function automatic logic nib_invalid(input logic [3:0] nib);
        return (nib > 4'd9);
    endfunction

endpackage : bcd_disp_pkg
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD nibble to 7-segment decoder. Digits 0..9
//               map to their glyphs; A..F show a dash and raise o_err.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg,
    output logic       o_err
);

    // Nibble lookup; anything outside 0..9 becomes a dash
    always_comb begin
        o_seg = SEG_DASH;
        o_err = nib_invalid(i_nib);
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule : bcd_to_7seg
`default_nettype wire

// File: rtl/bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_7seg_scan
// Description : Time-multiplexed driver for a 3-digit 7-segment display.
//               A prescaler paces digit slots of CLK_DIV cycles; new values
//               are staged in a pending register and only reach the display
//               register at a frame boundary, so a frame never shows a mix
//               of old and new digits.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on
//               the hundreds and tens digits (units always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   bcd,
    input  logic                      bcd_valid,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      bcd_err
);

    localparam int                    c_PRESC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0]  c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);

    logic [c_PRESC_W-1:0]      r_presc;
    digit_e                    r_idx;
    logic [4*NUM_DIGITS-1:0]   r_pend;
    logic                      r_pend_vld;
    logic [4*NUM_DIGITS-1:0]   r_disp;
    logic [6:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame_done;
    logic                      r_err;

    logic                      w_tick;
    logic                      w_frame;
    logic [3:0]                w_nib;
    logic [6:0]                w_dec_seg;
    logic                      w_dec_err;
    logic [6:0]                w_seg_next;
    logic [NUM_DIGITS-1:0]     w_an_next;
    logic                      w_disp_err;

    assign w_tick  = (r_presc == c_PRESC_MAX);
    assign w_frame = w_tick && (r_idx == DIG_HUNDREDS);

    // Prescaler: free-running 0..CLK_DIV-1, one tick per digit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit index: units -> tens -> hundreds -> units, one step per tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= DIG_UNITS;
        end else if (w_tick) begin
            if (r_idx == DIG_HUNDREDS) begin
                r_idx <= DIG_UNITS;
            end else begin
                r_idx <= digit_e'(r_idx + 2'd1);
            end
        end
    end

    // Staging: new values wait in r_pend until the frame boundary; a strobe
    // landing exactly on the boundary bypasses staging and wins over any
    // older pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_disp     <= '0;
        end else if (w_frame) begin
            if (bcd_valid) begin
                r_disp     <= bcd;
                r_pend_vld <= 1'b0;
            end else if (r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= 1'b0;
            end
        end else if (bcd_valid) begin
            r_pend     <= bcd;
            r_pend_vld <= 1'b1;
        end
    end

    // Select the nibble belonging to the active digit slot
    always_comb begin
        w_nib = r_disp[3:0];
        case (r_idx)
            DIG_UNITS:    w_nib = r_disp[3:0];
            DIG_TENS:     w_nib = r_disp[7:4];
            DIG_HUNDREDS: w_nib = r_disp[11:8];
            default:      w_nib = r_disp[3:0];
        endcase
    end

    bcd_to_7seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec_seg),
        .o_err (w_dec_err)
    );

    // Optional leading-zero suppression applied after decoding
    always_comb begin
        w_seg_next = w_dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if ((r_idx == DIG_HUNDREDS) && (r_disp[11:8] == 4'd0)) begin
            w_seg_next = SEG_BLANK;
        end
        if ((r_idx == DIG_TENS) && (r_disp[11:4] == 8'd0)) begin
            w_seg_next = SEG_BLANK;
        end
`endif
    end

    assign w_an_next  = NUM_DIGITS'(1) << r_idx;
    assign w_disp_err = nib_invalid(r_disp[3:0]) |
                        nib_invalid(r_disp[7:4]) |
                        nib_invalid(r_disp[11:8]);

    // Output registers: all display pins lag the index/display state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= SEG_BLANK;
            r_an         <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_seg        <= w_seg_next;
            r_an         <= w_an_next;
            r_frame_done <= w_frame;
            r_err        <= w_disp_err | w_dec_err;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;
    assign bcd_err    = r_err;

endmodule : bcd_7seg_scan
`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_7seg_scan
// Description : Scoreboard bench for bcd_7seg_scan with CLK_DIV=4. The
//               stimulus side pushes the value each upcoming frame must show;
//               the monitor pops one entry per 12-cycle frame and checks
//               an/seg/frame_done/bcd_err every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_7seg_scan;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 3 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd = 12'h000;
    logic        bcd_valid = 1'b0;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_done;
    logic        bcd_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] nxt_val = 12'h000;

    bcd_7seg_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference glyph for digit d of value v, independent of the DUT tables
    function automatic logic [6:0] ref_seg(input logic [11:0] v, input int d);
        logic [3:0] nib;
        logic [6:0] s;
        nib = v[4*d +: 4];
        case (nib)
            4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;  4'd4: s = 7'h66;  4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;  4'd7: s = 7'h07;  4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;  default: s = 7'h40;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 2 && v[11:8] == 4'd0) s = 7'h00;
        if (d == 1 && v[11:4] == 8'd0) s = 7'h00;
`endif
        return s;
    endfunction

    function automatic logic ref_err(input logic [11:0] v);
        return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9);
    endfunction

    // Monitor: samples on the falling edge, halfway between driving edges
    initial begin : p_monitor
        logic        prev_rst;
        int          pos;
        int          d;
        logic [11:0] cur;
        prev_rst = 1'b1;
        pos      = 0;
        cur      = 12'h000;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_seg", {9'd0, seg}, 16'h0000);
                chk("rst_an", {13'd0, an}, 16'h0000);
                chk("rst_frame_done", {15'd0, frame_done}, 16'h0000);
                chk("rst_bcd_err", {15'd0, bcd_err}, 16'h0000);
                pos = 0;
            end else begin
                if (pos == 0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_empty: got no expected frame, required one at t=%0t", $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                d = pos / CLK_DIV;
                chk($sformatf("an[v=%03h,pos=%0d]", cur, pos), {13'd0, an}, 16'(3'b001 << d));
                chk($sformatf("seg[v=%03h,pos=%0d]", cur, pos), {9'd0, seg}, {9'd0, ref_seg(cur, d)});
                chk($sformatf("frame_done[pos=%0d]", pos), {15'd0, frame_done}, {15'd0, (pos == FRAME - 1)});
                chk($sformatf("bcd_err[v=%03h]", cur), {15'd0, bcd_err}, {15'd0, ref_err(cur)});
                pos = (pos == FRAME - 1) ? 0 : pos + 1;
            end
            prev_rst = rst;
        end
    end

    // One frame of stimulus; c0/c1 are strobe positions (-1 = none).
    // Any strobe in the slot lands in the next frame, last one wins.
    task automatic run_slot(input logic [11:0] v0, input int c0,
                            input logic [11:0] v1, input int c1);
        for (int c = 0; c < FRAME; c++) begin
            bcd_valid = 1'b0;
            bcd       = 12'($urandom);
            if (c == c0) begin
                bcd = v0; bcd_valid = 1'b1; nxt_val = v0;
            end
            if (c == c1) begin
                bcd = v1; bcd_valid = 1'b1; nxt_val = v1;
            end
            @(posedge clk); #1;
        end
        bcd_valid = 1'b0;
        exp_q.push_back(nxt_val);
    endtask

    task automatic idle_slot();
        run_slot(12'h000, -1, 12'h000, -1);
    endtask

    // Strobe a value mid-frame, then reset before the boundary
    task automatic reset_mid_frame(input logic [11:0] v);
        for (int c = 0; c < 5; c++) begin
            bcd_valid = (c == 2);
            bcd       = (c == 2) ? v : 12'($urandom);
            @(posedge clk); #1;
        end
        bcd_valid = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst     = 1'b0;
        nxt_val = 12'h000;
        exp_q.push_back(nxt_val);
    endtask

    initial begin : p_stim
        exp_q.push_back(12'h000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        idle_slot();                                   // rotation, frame_done, 000
        run_slot(12'h255, 5, 12'h000, -1);             // mid-frame update
        idle_slot();
        run_slot(12'h128, FRAME - 1, 12'h000, -1);     // coincides with boundary
        idle_slot();
        run_slot(12'h777, 3, 12'h321, FRAME - 1);      // stale pending must not reappear
        idle_slot();
        run_slot(12'h111, 1, 12'h999, 8);              // last write wins
        run_slot(12'h1A3, 4, 12'h000, -1);             // invalid tens nibble
        idle_slot();
        run_slot(12'h123, 6, 12'h000, -1);             // error clears
        run_slot(12'h007, 0, 12'h000, -1);             // leading zeros
        run_slot(12'h070, 9, 12'h000, -1);
        run_slot(12'h100, 2, 12'h000, -1);
        run_slot(12'hF0E, 7, 12'h000, -1);
        idle_slot();
        reset_mid_frame(12'h456);                      // pending discarded
        idle_slot();
        idle_slot();
        run_slot(12'h864, 10, 12'h000, -1);
        idle_slot();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bcd_7seg_scan
`default_nettype wire
